// File: rtl/serial_sort_engine.sv
// Frame-based serial sorter: loads DEPTH signed words, bubble-sorts them through a
// circulating shift register and a hold register, then drains them in order.
// Optional build macro SORT_EARLY_EXIT_EN ends SORT after the first pass with no swaps.
module serial_sort_engine #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             desc_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_PASS = CW'(DEPTH - 2);

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } state_t;

  state_t state, state_next;

  logic signed [WIDTH-1:0] sr [DEPTH];
  logic signed [WIDTH-1:0] hold;
  logic signed [WIDTH-1:0] tail;
  logic signed [WIDTH-1:0] sr_in;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           step;
  logic [CW-1:0]           pass;
  logic                    desc;
  logic                    ready_q;
  logic                    shift_en;
  logic                    in_fire;
  logic                    out_fire;
  logic                    swap;
  logic                    sort_done;

  assign tail     = sr[DEPTH-1];
  assign in_fire  = in_valid && ready_q;
  assign out_fire = out_valid && out_ready;

  // The hold word keeps its place (is "swapped" past the tail) only when it strictly
  // wins in the active order, so equal words never change relative order.
  assign swap = desc ? (hold < tail) : (hold > tail);

`ifdef SORT_EARLY_EXIT_EN
  logic swapped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swapped <= 1'b0;
    end else if (state == SORT) begin
      if (step == '0) begin
        swapped <= 1'b0;
      end else if (step != LAST_STEP && swap) begin
        swapped <= 1'b1;
      end
    end
  end

  assign sort_done = (pass == LAST_PASS) || !swapped;
`else
  assign sort_done = (pass == LAST_PASS);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Pass layout: step 0 pulls the tail into hold (a zero bubble enters stage 0),
  // steps 1..DEPTH-1 compare, step DEPTH writes hold back as the bubble falls off.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    sr_in      = tail;
    case (state)
      LOAD: begin
        if (in_fire) begin
          shift_en = 1'b1;
          sr_in    = in_data;
          if (cnt == LAST_IDX) state_next = SORT;
        end
      end
      SORT: begin
        shift_en = 1'b1;
        if (step == '0) begin
          sr_in = '0;
        end else if (step == LAST_STEP) begin
          sr_in = hold;
          if (sort_done) state_next = DRAIN;
        end else begin
          sr_in = swap ? tail : hold;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          shift_en = 1'b1;
          if (cnt == LAST_IDX) state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (shift_en) begin
      sr[0] <= sr_in;
      for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      step    <= '0;
      pass    <= '0;
      hold    <= '0;
      desc    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= (state_next == LOAD);
      case (state)
        LOAD: begin
          if (in_fire) begin
            if (cnt == '0) desc <= desc_i;
            cnt  <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
            step <= '0;
            pass <= '0;
          end
        end
        SORT: begin
          if (step == LAST_STEP) begin
            step <= '0;
            pass <= pass + 1'b1;
          end else begin
            step <= step + 1'b1;
          end
          if (step == '0) begin
            hold <= tail;
          end else if (step != LAST_STEP && !swap) begin
            hold <= tail;
          end
        end
        DRAIN: begin
          if (out_fire) cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state == DRAIN);
  assign out_data  = out_valid ? tail : '0;
  assign out_last  = out_valid && (cnt == LAST_IDX);
  assign busy      = (state != LOAD);

endmodule

// File: tb/tb_serial_sort_engine.sv
// Self-checking bench for serial_sort_engine (WIDTH=8, DEPTH=4): directed table,
// mid-sort reset, and randomized stalled frames checked against a sorting model.
module tb_serial_sort_engine;

  localparam int W = 8;
  localparam int D = 4;
  localparam int FIXED_LAT = (D - 1) * (D + 1);
  localparam int NV = 5;
`ifdef SORT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  typedef logic signed [W-1:0] word_t;
  typedef logic [D-1:0][W-1:0] frame_t;

  typedef struct packed {
    frame_t     vals;
    logic       desc;
    logic       toggle;
    frame_t     exp;
    logic [7:0] lat_ee;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         desc_i = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_last;
  logic         busy;
  logic [W-1:0] out_data;

  int cyc = 0;
  int passed = 0;
  int total = 0;
  vec_t vecs [NV];

  serial_sort_engine #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .desc_i   (desc_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic frame_t mk(input int a, input int b, input int c, input int d);
    frame_t r;
    r[0] = W'(a);
    r[1] = W'(b);
    r[2] = W'(c);
    r[3] = W'(d);
    return r;
  endfunction

  // Reference: plain exchange sort by signed value, largest-first when descending.
  function automatic frame_t model(input frame_t v, input logic d);
    frame_t r;
    word_t a, b;
    r = v;
    for (int i = 0; i < D; i++) begin
      for (int j = i + 1; j < D; j++) begin
        a = r[i];
        b = r[j];
        if (d ? (b > a) : (b < a)) begin
          r[i] = b;
          r[j] = a;
        end
      end
    end
    return r;
  endfunction

  task automatic send_frame(input frame_t v, input logic d, input bit tog, input bit stall,
                            output int t_last);
    for (int i = 0; i < D; i++) begin
      int guard = 0;
      if (stall) repeat ($urandom_range(0, 2)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = v[i];
      desc_i   = tog ? (d ^ i[0]) : d;
      while (!in_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      @(negedge clk);
      in_valid = 1'b0;
    end
    t_last = cyc;
  endtask

  task automatic wait_valid(input int t_last, input int exp_lat, input string nm);
    int guard = 0;
    in_valid = 1'b1;
    while (!out_valid && guard < 500) begin
      in_data   = W'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      chk({nm, "_sort_in_ready"}, in_ready, 0);
      chk({nm, "_sort_busy"}, busy, 1);
      @(negedge clk);
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (!out_valid) chk({nm, "_valid_timeout"}, 0, 1);
    else if (exp_lat >= 0) chk({nm, "_latency"}, cyc - t_last, exp_lat);
  endtask

  task automatic recv_frame(input frame_t e, input bit stall, input string nm);
    int k = 0;
    int guard = 0;
    logic [W-1:0] held = '0;
    bit have = 1'b0;
    while (k < D && guard < 1000) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!out_valid) begin
        chk({nm, "_out_valid"}, out_valid, 1);
        break;
      end
      chk({nm, "_in_ready"}, in_ready, 0);
      chk({nm, "_busy"}, busy, 1);
      if (have) chk({nm, "_stable"}, int'(out_data), int'(held));
      if (out_ready) begin
        chk($sformatf("%s_data%0d", nm, k), int'($signed(out_data)), int'($signed(e[k])));
        chk($sformatf("%s_last%0d", nm, k), out_last, (k == D - 1) ? 1 : 0);
        k++;
        have = 1'b0;
      end else begin
        held = out_data;
        have = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    chk({nm, "_done_out_valid"}, out_valid, 0);
    chk({nm, "_done_in_ready"}, in_ready, 1);
  endtask

  initial begin
    int tl;
    frame_t v;
    logic d;

    vecs[0] = '{vals: mk(7, -3, 12, 0),     desc: 1'b0, toggle: 1'b0, exp: mk(-3, 0, 7, 12),     lat_ee: 8'd15};
    vecs[1] = '{vals: mk(5, 5, -1, 9),      desc: 1'b1, toggle: 1'b1, exp: mk(9, 5, 5, -1),      lat_ee: 8'd15};
    vecs[2] = '{vals: mk(-128, 127, -1, 1), desc: 1'b0, toggle: 1'b0, exp: mk(-128, -1, 1, 127), lat_ee: 8'd10};
    vecs[3] = '{vals: mk(1, 2, 3, 4),       desc: 1'b0, toggle: 1'b0, exp: mk(1, 2, 3, 4),       lat_ee: 8'd5};
    vecs[4] = '{vals: mk(1, 2, 3, 4),       desc: 1'b1, toggle: 1'b0, exp: mk(4, 3, 2, 1),       lat_ee: 8'd15};

    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    chk("rst_hold_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);

    for (int i = 0; i < NV; i++) begin
      send_frame(vecs[i].vals, vecs[i].desc, vecs[i].toggle, 1'b0, tl);
      wait_valid(tl, EE ? int'(vecs[i].lat_ee) : FIXED_LAT, $sformatf("vec%0d", i));
      recv_frame(vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
    end

    // Abort a frame during the second sort pass.
    send_frame(mk(9, -5, 3, 1), 1'b0, 1'b0, 1'b0, tl);
    repeat (D + 3) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_last", out_last, 0);
    chk("abort_out_data", int'(out_data), 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_release_in_ready", in_ready, 1);
    send_frame(mk(4, 3, 2, 1), 1'b0, 1'b0, 1'b0, tl);
    wait_valid(tl, FIXED_LAT, "after_abort");
    recv_frame(mk(1, 2, 3, 4), 1'b0, "after_abort");

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < D; i++) begin
        if (f[0]) v[i] = W'($urandom_range(0, 4) - 2);
        else      v[i] = W'($urandom);
      end
      d = 1'($urandom);
      send_frame(v, d, 1'b1, 1'b1, tl);
      wait_valid(tl, -1, $sformatf("rnd%0d", f));
      recv_frame(model(v, d), 1'b1, $sformatf("rnd%0d", f));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
